// File: rtl/spi_target.sv
// SPI mode-0 responder (MSB first, active-low select) running entirely in the clk domain.
// SPI pins are oversampled; received bytes pop out on rx_valid, transmit bytes come from a one-entry buffer.
module spi_target #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  state_t                 state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_W-2:0]      shift_in;
  logic [DATA_W-1:0]      shift_out;
  logic [DATA_W-1:0]      next_in;
  logic                   buf_full;
  logic [DATA_W-1:0]      buf_data;
  logic [DATA_W-1:0]      load_val;
  logic                   do_load;

  // Synchronizers reset to the idle line levels so no false edge is seen after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  assign next_in  = {shift_in, mosi_s};
  assign load_val = buf_full ? buf_data : '0;
  // A cs_n rise takes priority over any clock edge in the same cycle.
  assign do_load  = ((state == IDLE) && cs_fall) ||
                    ((state == ACTIVE) && !cs_rise && sclk_fall && (bit_cnt == '0));
  assign tx_ready = ~buf_full;

  // A write coinciding with a load is captured; the load itself saw an empty buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_full <= 1'b0;
      buf_data <= '0;
    end else if (tx_valid && !buf_full) begin
      buf_full <= 1'b1;
      buf_data <= tx_data;
    end else if (do_load) begin
      buf_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_in    <= '0;
      shift_out   <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      if (do_load) begin
        shift_out   <= load_val;
        spi_miso    <= load_val[DATA_W-1];
        tx_underrun <= ~buf_full;
      end
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state       <= ACTIVE;
            bit_cnt     <= '0;
            spi_miso_oe <= 1'b1;
          end else begin
            spi_miso_oe <= 1'b0;
            spi_miso    <= 1'b0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            spi_miso_oe <= 1'b0;
            spi_miso    <= 1'b0;
          end else if (sclk_rise) begin
            shift_in <= next_in[DATA_W-2:0];
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              rx_data  <= next_in;
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else if (sclk_fall && (bit_cnt != '0)) begin
            shift_out <= shift_out << 1;
            spi_miso  <= shift_out[DATA_W-2];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Randomized bench for spi_target: an initiator drives mode-0 frames while a queue-based
// model predicts MISO bits, received bytes and underrun pulses.
module tb_spi_target;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       spi_miso, spi_miso_oe, tx_ready, rx_valid, tx_underrun;
  logic [7:0] rx_data;

  spi_target #(.DATA_W(8), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_rx[$];
  int         exp_under = 0;
  int         under_cnt = 0;
  logic [7:0] mosi_b[4];
  logic [7:0] miso_s[4];
  logic [7:0] last_rx = 8'h00;
  int         cs_hi = 0;
  int         cs_lo = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every byte load takes the oldest buffered byte, or sends zero and counts an underrun.
  function automatic logic [7:0] model_load();
    if (tx_q.size() > 0) return tx_q.pop_front();
    exp_under++;
    return 8'h00;
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    if (rst) begin
      cs_hi   = 0;
      cs_lo   = 0;
      last_rx = 8'h00;
    end else begin
      if (spi_cs_n) begin cs_hi++; cs_lo = 0; end
      else begin cs_lo++; cs_hi = 0; end
      if (rx_valid) begin
        if (exp_rx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got rx_valid with %0h, expected no byte at %0t", rx_data, $time);
        end else begin
          chk("rx_data", rx_data, exp_rx[0]);
          last_rx = exp_rx.pop_front();
        end
      end else begin
        chk("rx_hold", rx_data, last_rx);
      end
      if (tx_underrun) under_cnt++;
      if (cs_hi > SS + 2) begin
        chk("idle_oe", spi_miso_oe, 0);
        chk("idle_miso", spi_miso, 0);
      end
      if (cs_lo > SS + 2) chk("active_oe", spi_miso_oe, 1);
    end
  end

  task automatic write_tx(input logic [7:0] b);
    bit r = 1'b0;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      r = tx_ready;
      @(negedge clk);
      if (r) break;
    end
    tx_valid = 1'b0;
    if (r) tx_q.push_back(b);
    else begin
      checks++;
      errors++;
      $display("FAIL write_timeout: got tx_ready low for 3000 cycles, expected acceptance of %0h", b);
    end
  endtask

  task automatic frame(input int nbytes, input int pbits, input int h, input bit do_reset);
    logic [7:0] cur;
    int nb;
    @(negedge clk);
    spi_cs_n = 1'b0;
    cur = model_load();
    repeat (h) @(negedge clk);
    for (int b = 0; b < nbytes + ((pbits > 0) ? 1 : 0); b++) begin
      nb = (b < nbytes) ? 8 : pbits;
      for (int i = 0; i < nb; i++) begin
        spi_mosi = mosi_b[b][7-i];
        repeat (h) @(negedge clk);
        spi_clk = 1'b1;
        miso_s[b][7-i] = spi_miso;
        chk("miso_bit", spi_miso, cur[7-i]);
        chk("miso_oe", spi_miso_oe, 1);
        if (i == 7) exp_rx.push_back(mosi_b[b]);
        repeat (h) @(negedge clk);
        spi_clk = 1'b0;
        if (i == 7) cur = model_load();
      end
    end
    repeat (h) @(negedge clk);
    if (do_reset) begin
      #2;
      rst      = 1'b1;
      spi_cs_n = 1'b1;
      #1;
      chk("rst_oe", spi_miso_oe, 0);
      chk("rst_miso", spi_miso, 0);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_underrun", tx_underrun, 0);
      tx_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
    end else begin
      spi_cs_n = 1'b1;
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic end_check();
    repeat (10) @(negedge clk);
    chk("underrun_count", under_cnt, exp_under);
    chk("rx_outstanding", exp_rx.size(), 0);
    chk("tx_ready_idle", tx_ready, (tx_q.size() == 0));
  endtask

  initial begin
    int u0, nbytes, pbits, h, nref;
    repeat (3) @(negedge clk);
    chk("reset_oe", spi_miso_oe, 0);
    chk("reset_miso", spi_miso, 0);
    chk("reset_tx_ready", tx_ready, 1);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_underrun", tx_underrun, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    write_tx(8'hA5);
    mosi_b[0] = 8'h3C;
    frame(1, 0, 8, 1'b0);
    end_check();
    chk("single_miso", miso_s[0], 8'hA5);
    chk("single_rx", rx_data, 8'h3C);

    write_tx(8'h11);
    mosi_b[0] = 8'hF0;
    mosi_b[1] = 8'h0F;
    fork
      frame(2, 0, 8, 1'b0);
      begin repeat (SS + 4) @(negedge clk); write_tx(8'h22); end
    join
    end_check();
    chk("b2b_miso0", miso_s[0], 8'h11);
    chk("b2b_miso1", miso_s[1], 8'h22);
    chk("b2b_rx", rx_data, 8'h0F);

    mosi_b[0] = 8'hFF;
    frame(0, 5, 8, 1'b0);
    end_check();
    chk("abort_rx_kept", rx_data, 8'h0F);
    chk("abort_oe", spi_miso_oe, 0);
    mosi_b[0] = 8'h55;
    frame(1, 0, 6, 1'b0);
    end_check();
    chk("after_abort_rx", rx_data, 8'h55);

    u0 = under_cnt;
    mosi_b[0] = 8'h81;
    frame(1, 0, 5, 1'b0);
    end_check();
    chk("underrun_miso", miso_s[0], 8'h00);
    chk("underrun_rx", rx_data, 8'h81);
    chk("underrun_pulses", under_cnt - u0, 2);

    write_tx(8'h9A);
    mosi_b[0] = 8'hE7;
    frame(0, 3, 8, 1'b1);
    mosi_b[0] = 8'hC3;
    frame(1, 0, 8, 1'b0);
    end_check();
    chk("post_reset_miso", miso_s[0], 8'h00);
    chk("post_reset_rx", rx_data, 8'hC3);

    write_tx(8'h44);
    mosi_b[0] = 8'h12;
    mosi_b[1] = 8'h34;
    fork
      write_tx(8'h77);
      begin
        repeat (20) begin @(negedge clk); chk("hs_hold_ready", tx_ready, 0); end
        frame(2, 0, 7, 1'b0);
      end
    join
    end_check();
    chk("hs_miso0", miso_s[0], 8'h44);
    chk("hs_miso1", miso_s[1], 8'h77);
    mosi_b[0] = 8'h5A;
    frame(1, 0, 4, 1'b0);
    end_check();
    chk("hs_no_resend", miso_s[0], 8'h00);

    for (int it = 0; it < 25; it++) begin
      nbytes = int'($urandom_range(1, 3));
      pbits  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      h      = int'($urandom_range(SS + 2, 10));
      nref   = int'($urandom_range(0, nbytes));
      for (int b = 0; b < 4; b++) mosi_b[b] = 8'($urandom);
      if (tx_q.size() == 0 && $urandom_range(0, 1) == 1) write_tx(8'($urandom));
      fork
        frame(nbytes, pbits, h, 1'b0);
        begin
          repeat (SS + 4) @(negedge clk);
          for (int k = 0; k < nref; k++) write_tx(8'($urandom));
        end
      join
      end_check();
      $display("frame %0d: bytes=%0d partial_bits=%0d half=%0d refills=%0d rx_data=%0h", it, nbytes, pbits, h, nref, rx_data);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion, expected finish before 90000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
